// File: rtl/sayuru_mem_responder.sv
// Word-addressed RAM behind a req/gnt/rvalid port with grant and response latency.
// Optional read/write transaction counters: define SAYURU_MEM_COUNTERS_EN.
module sayuru_mem_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int GNT_LATENCY    = 2,
    parameter int RVALID_LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
`ifdef SAYURU_MEM_COUNTERS_EN
    output logic [31:0]             read_count_o,
    output logic [31:0]             write_count_o,
`endif
    output logic [DATA_WIDTH-1:0]   data_rdata_o
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = $clog2(MEM_DEPTH);
    localparam logic [3:0] GLAT  = 4'(GNT_LATENCY);
    localparam logic [3:0] RLOAD = 4'(RVALID_LATENCY - 1);

    typedef enum logic {
        IDLE,
        WAIT_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              gcnt_q, gcnt_d;
    logic [3:0]              rcnt_q, rcnt_d;
    logic [DATA_WIDTH-1:0]   resp_q, resp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    gnt;
    logic                    rv_cyc;
    logic [IDXW-1:0]         idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic                    unused_addr;

    assign idx         = data_addr_i[OFFW +: IDXW];
    assign rd_word     = mem_q[idx];
    assign unused_addr = ^data_addr_i;

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        rcnt_d  = rcnt_q;
        resp_d  = resp_q;
        rv_cyc  = (state_q == WAIT_RESP) && (rcnt_q == 4'd0);
        gnt     = rst_n && data_req_i && (gcnt_q == GLAT)
                  && ((state_q == IDLE) || rv_cyc);

        if (!data_req_i || gnt) begin
            gcnt_d = 4'd0;
        end else if ((state_q == IDLE) || rv_cyc) begin
            gcnt_d = gcnt_q + 4'd1;
        end

        if (gnt) begin
            state_d = WAIT_RESP;
            rcnt_d  = RLOAD;
            resp_d  = data_we_i ? '0 : rd_word;
        end else if (rv_cyc) begin
            state_d = IDLE;
        end else if (state_q == WAIT_RESP) begin
            rcnt_d = rcnt_q - 4'd1;
        end

        // Response is registered, so decide one cycle ahead from next state
        rvalid_d = (state_d == WAIT_RESP) && (rcnt_d == 4'd0);
        rdata_d  = rvalid_d ? resp_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gcnt_q   <= 4'd0;
            rcnt_q   <= 4'd0;
            resp_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gcnt_q   <= gcnt_d;
            rcnt_q   <= rcnt_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt && data_we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (data_be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

`ifdef SAYURU_MEM_COUNTERS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (gnt) begin
            if (data_we_i) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign read_count_o  = rd_cnt_q;
    assign write_count_o = wr_cnt_q;
`endif

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;

endmodule

// File: doc/sayuru_mem_responder.md
# sayuru_mem_responder

Memory-side responder for the core memory protocol (req/gnt/rvalid) driven by the Sayuru caches on their miss/writeback port (`out_data_*`). It owns a word-addressed RAM, accepts one transaction at a time with a configurable grant latency and response latency, and applies byte-enabled writes. It is the synthesisable backing store and latency model placed behind `sayuru_nway` in cache test systems.

## Interface
- ADDR_WIDTH, 16: byte address width.
- DATA_WIDTH, 32: data word width. Must be a multiple of 8.
- MEM_DEPTH, 1024: RAM depth in words. Must be a power of two.
- GNT_LATENCY, 2: stall cycles before `data_gnt_o`. Range 0..15.
- RVALID_LATENCY, 3: cycles from the grant cycle to the `data_rvalid_o` cycle. Range 1..15.

Ports:
- clk  in  1  clock. All logic is rising-edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- data_req_i  in  1  request. Held high with the address and controls until granted.
- data_gnt_o  out  1  one-cycle grant pulse. Request fields are sampled in this cycle.
- data_rvalid_o  out  1  one-cycle response pulse. Issued for both reads and writes.
- data_addr_i  in  ADDR_WIDTH  byte address.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  DATA_WIDTH/8  byte enables for writes.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_rdata_o  out  DATA_WIDTH  read data. Valid only while `data_rvalid_o` = 1.

## Operation
- States:
  - IDLE: no transaction outstanding.
  - WAIT_RESP: a transaction has been granted and its response is pending.
- Grant counter (gcnt):
  - Counts consecutive cycles with `data_req_i` = 1 while the block is in IDLE, or in the cycle where `data_rvalid_o` = 1.
  - Clears to 0 whenever `data_req_i` = 0.
- `data_gnt_o` = `data_req_i` AND (gcnt == GNT_LATENCY) AND (state == IDLE, or the current cycle is the rvalid cycle).
  - This is combinational on `data_req_i`. With GNT_LATENCY = 0 the grant comes in the same cycle as the request.
- On the grant edge:
  - Word index = `data_addr_i[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)]`. Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH words. Low byte-offset bits are ignored.
  - Write: each byte lane with its `be` bit set is written to RAM. The other lanes are unchanged.
  - Read: the RAM word is captured into the response register. The RAM read happens before any later write, so a read followed by a write to the same address returns the old data.
  - State moves to WAIT_RESP, with the response counter loaded to RVALID_LATENCY-1.
- WAIT_RESP:
  - The response counter decrements each cycle.
  - `data_rvalid_o` = 1 for exactly one cycle when the counter reaches 0.
  - In that cycle `data_rdata_o` = the captured word for a read, and 0 for a write.
  - The state returns to IDLE on that edge unless a new grant occurs in the same cycle. In that case it reloads and stays in WAIT_RESP.
- A request dropped before its grant is discarded and gcnt clears. No response is produced.
- Requests are never granted while a response is outstanding, except in the rvalid cycle itself. At most one transaction is ever in flight.

## Timing
- Reset state:
  - `data_gnt_o` = 0, `data_rvalid_o` = 0, `data_rdata_o` = 0.
  - state = IDLE, gcnt = 0, response counter = 0.
  - RAM contents are not reset. They are undefined until written.
- Reset asserted mid-transaction aborts it. No rvalid is issued. A write already granted has already been applied.
- Request to grant: GNT_LATENCY cycles.
- Grant to rvalid: RVALID_LATENCY cycles.
- Minimum spacing between back-to-back grants: RVALID_LATENCY cycles when GNT_LATENCY = 0; otherwise RVALID_LATENCY + GNT_LATENCY cycles.
- `data_rdata_o` is registered. It returns to 0 in every cycle without rvalid.

## Configuration
- Macro: SAYURU_MEM_COUNTERS_EN.
- Defined:
  - Adds the ports `read_count_o` and `write_count_o` (out, 32 bits each).
  - Each increments on a granted read or write respectively.
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- **Basic write:** defaults; write addr 0x0010, wdata 0xDEADBEEF, be 0xF, req held. Required: gnt 2 cycles after req; rvalid 3 cycles after gnt with rdata 0.
- **Partial write and readback:** write 0x11223344 (be 0xF) to 0x0020, then write 0xAABBCCDD with be 0x5 to 0x0020, then read 0x0020. Required: rdata 0x11BB33DD.
- **Address wrap:** MEM_DEPTH 1024; write 0xCAFEF00D to 0x1004, read 0x0004. Required: rdata 0xCAFEF00D.
- **Back-to-back requests:** GNT_LATENCY 0, RVALID_LATENCY 1, two reads issued back-to-back. Required: the second gnt coincides with the first rvalid; rvalids arrive on consecutive cycles.
- **Dropped request:** req high 1 cycle, then low, with GNT_LATENCY 2. Required: no gnt, no rvalid, gcnt back to 0. A later request is granted exactly 2 cycles after it is raised.
- **Reset mid-response:** rst_n pulsed low between gnt and rvalid of a read. Required: gnt, rvalid and rdata go 0 immediately; no rvalid after release. With SAYURU_MEM_COUNTERS_EN, both counters read 0.
